// File: rtl/inst_fetch_ctrl_pkg.sv
// Purpose: shared constants and types for the instruction-fetch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package inst_fetch_ctrl_pkg;

  // Exception codes carried on the decode bundle.
  localparam logic [4:0] EXC_ADEL = 5'h04;  // misaligned fetch address
  localparam logic [4:0] EXC_TLBL = 5'h02;  // TLB refill / invalid on fetch

  // Boot vector used when the parent does not override RESET_PC.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  // Fetch sequencing states.
  typedef enum logic [2:0] {
    ST_REQ    = 3'd0,  // translate pc and present the cache request
    ST_WAIT   = 3'd1,  // request accepted, waiting for read data
    ST_CANCEL = 3'd2,  // redirected while a request is in flight, drain it
    ST_HOLD   = 3'd3,  // instruction bundle waiting for decode
    ST_EXC    = 3'd4,  // fault bundle waiting for decode
    ST_HALT   = 3'd5   // fault delivered, idle until redirect
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Purpose: fetch PC sequencer feeding MMU, I-cache and decode with one request in flight.
// Latency: hit with addr_ok in cycle 0 and data_ok in cycle 1 gives out_valid in cycle 2; a fault gives out_valid next cycle.
// Backpressure: bundle held stable while out_ready is low; no new fetch until decode takes it.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mmu_en,
  output logic [31:0] mmu_vaddr,
  input  logic        mmu_psyaddr_ena,
  input  logic [31:0] mmu_psyaddr,
  input  logic        mmu_tlb_refill,
  input  logic        mmu_tlb_invalid,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_addr_ok,
  input  logic        ic_data_ok,
  input  logic [31:0] ic_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_exc,
  output logic [4:0]  out_exccode,
  output logic        out_tlb_refill
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         out_valid_q;
  logic [31:0]  out_pc_q;
  logic [31:0]  out_inst_q;
  logic         out_exc_q;
  logic [4:0]   out_exccode_q;
  logic         out_tlb_refill_q;

  logic in_req;
  logic adel;
  logic fault;
  logic req_taken;

  // Fault classification: misalignment outranks any translator result.
  assign in_req    = (state_q == ST_REQ);
  assign adel      = (pc_q[1:0] != 2'b00);
  assign fault     = adel | mmu_tlb_refill | mmu_tlb_invalid;

  // The translator drives psyaddr_ena only for a usable hit, so the cache
  // request waits for it rather than sending a stale physical address.
  assign mmu_en    = in_req;
  assign mmu_vaddr = pc_q;
  assign ic_req    = in_req & ~fault & mmu_psyaddr_ena;
  assign ic_addr   = mmu_psyaddr;
  assign req_taken = ic_req & ic_addr_ok;

  assign out_valid      = out_valid_q;
  assign out_pc         = out_pc_q;
  assign out_inst       = out_inst_q;
  assign out_exc        = out_exc_q;
  assign out_exccode    = out_exccode_q;
  assign out_tlb_refill = out_tlb_refill_q;

  // Fetch FSM with registered decode bundle; redirect overrides everything.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= ST_REQ;
      pc_q             <= RESET_PC;
      out_valid_q      <= 1'b0;
      out_pc_q         <= '0;
      out_inst_q       <= '0;
      out_exc_q        <= 1'b0;
      out_exccode_q    <= '0;
      out_tlb_refill_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q        <= redirect_pc;
      out_valid_q <= 1'b0;
      case (state_q)
        // A request accepted this cycle still owes us a data beat.
        ST_REQ:    state_q <= req_taken ? ST_CANCEL : ST_REQ;
        // Data landing with the redirect closes the request; drop it.
        ST_WAIT:   state_q <= ic_data_ok ? ST_REQ : ST_CANCEL;
        // Still draining: only the restart pc changes.
        ST_CANCEL: state_q <= ic_data_ok ? ST_REQ : ST_CANCEL;
        default:   state_q <= ST_REQ;
      endcase
    end else begin
      case (state_q)
        ST_REQ: begin
          if (fault) begin
            out_valid_q      <= 1'b1;
            out_pc_q         <= pc_q;
            out_inst_q       <= '0;
            out_exc_q        <= 1'b1;
            out_exccode_q    <= adel ? EXC_ADEL : EXC_TLBL;
            out_tlb_refill_q <= ~adel & mmu_tlb_refill;
            state_q          <= ST_EXC;
          end else if (req_taken) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ic_data_ok) begin
            out_valid_q      <= 1'b1;
            out_pc_q         <= pc_q;
            out_inst_q       <= ic_rdata;
            out_exc_q        <= 1'b0;
            out_exccode_q    <= '0;
            out_tlb_refill_q <= 1'b0;
            state_q          <= ST_HOLD;
          end
        end
        ST_CANCEL: begin
          if (ic_data_ok) begin
            state_q <= ST_REQ;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            pc_q        <= pc_q + 32'd4;
            state_q     <= ST_REQ;
          end
        end
        ST_EXC: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_HALT;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  // Read data may only arrive while a request is outstanding.
  a_data_ok_outstanding : assert property (
    @(posedge clk) disable iff (!resetn)
    ic_data_ok |-> (state_q == ST_WAIT || state_q == ST_CANCEL)
  );

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Purpose: directed self-checking bench for inst_fetch_ctrl.
// Latency: inputs change on the falling edge, outputs sampled 1 ns later.
// Backpressure: out_ready driven directly by the step sequence.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mmu_en;
  logic [31:0] mmu_vaddr;
  logic        mmu_psyaddr_ena = 1'b0;
  logic [31:0] mmu_psyaddr = '0;
  logic        mmu_tlb_refill = 1'b0;
  logic        mmu_tlb_invalid = 1'b0;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_addr_ok = 1'b0;
  logic        ic_data_ok = 1'b0;
  logic [31:0] ic_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_exc;
  logic [4:0]  out_exccode;
  logic        out_tlb_refill;

  int vectors = 0;
  int miscompares = 0;

  inst_fetch_ctrl dut (
    .clk             (clk),
    .resetn          (resetn),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .mmu_en          (mmu_en),
    .mmu_vaddr       (mmu_vaddr),
    .mmu_psyaddr_ena (mmu_psyaddr_ena),
    .mmu_psyaddr     (mmu_psyaddr),
    .mmu_tlb_refill  (mmu_tlb_refill),
    .mmu_tlb_invalid (mmu_tlb_invalid),
    .ic_req          (ic_req),
    .ic_addr         (ic_addr),
    .ic_addr_ok      (ic_addr_ok),
    .ic_data_ok      (ic_data_ok),
    .ic_rdata        (ic_rdata),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_exc         (out_exc),
    .out_exccode     (out_exccode),
    .out_tlb_refill  (out_tlb_refill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; stimulus is applied there.
  task automatic step();
    @(negedge clk);
  endtask

  // Let combinational outputs settle after a stimulus change.
  task automatic settle();
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [31:0] held_pc;
    logic [31:0] held_inst;

    // ---------------- reset ----------------
    step(); step();
    settle();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_exc", {31'd0, out_exc}, 32'd0);
    chk("rst_vaddr", mmu_vaddr, 32'hBFC0_0000);
    chk("rst_mmu_en", {31'd0, mmu_en}, 32'd1);
    resetn = 1'b1;

    // ---------------- 1: plain hit at boot vector ----------------
    step();
    mmu_psyaddr_ena = 1'b1; mmu_psyaddr = 32'h1FC0_0000; ic_addr_ok = 1'b1;
    settle();
    chk("t1_ic_req", {31'd0, ic_req}, 32'd1);
    chk("t1_ic_addr", ic_addr, 32'h1FC0_0000);
    step();                                   // WAIT
    ic_addr_ok = 1'b0; mmu_psyaddr_ena = 1'b0;
    settle();
    chk("t1_wait_no_req", {31'd0, ic_req}, 32'd0);
    step();                                   // still WAIT, data now
    ic_data_ok = 1'b1; ic_rdata = 32'h2408_0001;
    step();                                   // HOLD
    ic_data_ok = 1'b0;
    settle();
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_out_pc", out_pc, 32'hBFC0_0000);
    chk("t1_out_inst", out_inst, 32'h2408_0001);
    chk("t1_out_exc", {31'd0, out_exc}, 32'd0);
    out_ready = 1'b1;
    step();                                   // REQ at +4
    out_ready = 1'b0;
    settle();
    chk("t1_next_vaddr", mmu_vaddr, 32'hBFC0_0004);
    chk("t1_valid_drop", {31'd0, out_valid}, 32'd0);

    // ---------------- 2: misaligned redirect -> AdEL ----------------
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0002;
    step();                                   // REQ at misaligned pc
    redirect_valid = 1'b0; mmu_psyaddr_ena = 1'b1; mmu_psyaddr = 32'h0000_0002;
    settle();
    chk("t2_vaddr", mmu_vaddr, 32'h8000_0002);
    chk("t2_no_req", {31'd0, ic_req}, 32'd0);
    step();                                   // EXC
    settle();
    chk("t2_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_out_exc", {31'd0, out_exc}, 32'd1);
    chk("t2_exccode", {27'd0, out_exccode}, 32'h04);
    chk("t2_out_pc", out_pc, 32'h8000_0002);
    chk("t2_out_inst", out_inst, 32'd0);
    chk("t2_refill", {31'd0, out_tlb_refill}, 32'd0);
    chk("t2_exc_no_req", {31'd0, ic_req}, 32'd0);
    out_ready = 1'b1;
    step();                                   // HALT
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t2_halt_mmu_en", {31'd0, mmu_en}, 32'd0);
      chk("t2_halt_no_req", {31'd0, ic_req}, 32'd0);
      chk("t2_halt_valid", {31'd0, out_valid}, 32'd0);
      step();
    end

    // ---------------- 3: TLB refill then TLB invalid ----------------
    mmu_psyaddr_ena = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0000;
    step();                                   // REQ
    redirect_valid = 1'b0; mmu_tlb_refill = 1'b1;
    settle();
    chk("t3_vaddr", mmu_vaddr, 32'h0040_0000);
    chk("t3_no_req", {31'd0, ic_req}, 32'd0);
    step();                                   // EXC
    mmu_tlb_refill = 1'b0;
    settle();
    chk("t3_exccode_ref", {27'd0, out_exccode}, 32'h02);
    chk("t3_refill_1", {31'd0, out_tlb_refill}, 32'd1);
    out_ready = 1'b1;
    step();                                   // HALT
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0000;
    step();                                   // REQ
    redirect_valid = 1'b0; mmu_tlb_invalid = 1'b1;
    step();                                   // EXC
    mmu_tlb_invalid = 1'b0;
    settle();
    chk("t3_inv_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_exccode_inv", {27'd0, out_exccode}, 32'h02);
    chk("t3_refill_0", {31'd0, out_tlb_refill}, 32'd0);
    // redirect straight out of EXC without a handshake
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    step();                                   // REQ
    redirect_valid = 1'b0;
    settle();
    chk("t3_exc_flush", {31'd0, out_valid}, 32'd0);

    // ---------------- 4: redirect in WAIT, late data discarded ----------------
    mmu_psyaddr_ena = 1'b1; mmu_psyaddr = 32'h0000_0100; ic_addr_ok = 1'b1;
    settle();
    chk("t4_ic_addr0", ic_addr, 32'h0000_0100);
    step();                                   // WAIT
    ic_addr_ok = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
    step();                                   // CANCEL
    redirect_valid = 1'b0; mmu_psyaddr = 32'h0000_1000;
    settle();
    chk("t4_cancel_no_req", {31'd0, ic_req}, 32'd0);
    chk("t4_cancel_mmu_en", {31'd0, mmu_en}, 32'd0);
    step();
    step();
    ic_data_ok = 1'b1; ic_rdata = 32'hDEAD_BEEF;
    step();                                   // REQ at new pc
    ic_data_ok = 1'b0;
    settle();
    chk("t4_no_bundle", {31'd0, out_valid}, 32'd0);
    chk("t4_vaddr", mmu_vaddr, 32'h8000_1000);
    chk("t4_ic_req", {31'd0, ic_req}, 32'd1);
    chk("t4_ic_addr", ic_addr, 32'h0000_1000);
    ic_addr_ok = 1'b1;
    step();                                   // WAIT
    ic_addr_ok = 1'b0; ic_data_ok = 1'b1; ic_rdata = 32'h3C1D_0000;
    step();                                   // HOLD
    ic_data_ok = 1'b0;
    settle();
    chk("t4_out_pc", out_pc, 32'h8000_1000);
    chk("t4_out_inst", out_inst, 32'h3C1D_0000);

    // ---------------- 5: decode stall, then pc wrap ----------------
    held_pc = 32'h8000_1000;
    held_inst = 32'h3C1D_0000;
    for (int i = 0; i < 5; i++) begin
      step();
      settle();
      chk("t5_stall_valid", {31'd0, out_valid}, 32'd1);
      chk("t5_stall_pc", out_pc, held_pc);
      chk("t5_stall_inst", out_inst, held_inst);
      chk("t5_stall_no_req", {31'd0, ic_req}, 32'd0);
    end
    out_ready = 1'b1;
    step();                                   // REQ at +4
    out_ready = 1'b0; mmu_psyaddr_ena = 1'b0;
    settle();
    chk("t5_next_vaddr", mmu_vaddr, 32'h8000_1004);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();                                   // REQ at top of space
    redirect_valid = 1'b0;
    mmu_psyaddr_ena = 1'b1; mmu_psyaddr = 32'h1FFF_FFFC; ic_addr_ok = 1'b1;
    step();                                   // WAIT
    ic_addr_ok = 1'b0; mmu_psyaddr_ena = 1'b0;
    ic_data_ok = 1'b1; ic_rdata = 32'h1234_5678;
    step();                                   // HOLD
    ic_data_ok = 1'b0;
    settle();
    chk("t5_top_pc", out_pc, 32'hFFFF_FFFC);
    out_ready = 1'b1;
    step();                                   // REQ at wrapped pc
    out_ready = 1'b0;
    settle();
    chk("t5_wrap_vaddr", mmu_vaddr, 32'h0000_0000);

    // ---------------- 6: redirect coincident with data_ok ----------------
    mmu_psyaddr_ena = 1'b1; mmu_psyaddr = 32'h0000_0000; ic_addr_ok = 1'b1;
    step();                                   // WAIT
    ic_addr_ok = 1'b0; mmu_psyaddr_ena = 1'b0;
    ic_data_ok = 1'b1; ic_rdata = 32'hBAAD_F00D;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_2000;
    step();                                   // REQ directly
    ic_data_ok = 1'b0; redirect_valid = 1'b0;
    settle();
    chk("t6_no_bundle", {31'd0, out_valid}, 32'd0);
    chk("t6_req_state", {31'd0, mmu_en}, 32'd1);
    chk("t6_vaddr", mmu_vaddr, 32'h8000_2000);
    mmu_psyaddr_ena = 1'b1; mmu_psyaddr = 32'h0000_2000; ic_addr_ok = 1'b1;
    settle();
    chk("t6_ic_req", {31'd0, ic_req}, 32'd1);
    step();                                   // WAIT
    ic_addr_ok = 1'b0; mmu_psyaddr_ena = 1'b0;
    ic_data_ok = 1'b1; ic_rdata = 32'h1111_2222;
    step();                                   // HOLD
    ic_data_ok = 1'b0;
    settle();
    chk("t6_out_pc", out_pc, 32'h8000_2000);
    chk("t6_out_inst", out_inst, 32'h1111_2222);

    // ---------------- 7: redirect while request accepted in REQ ----------------
    out_ready = 1'b1;
    step();                                   // REQ at 0x8000_2004
    out_ready = 1'b0;
    mmu_psyaddr_ena = 1'b1; mmu_psyaddr = 32'h0000_2004; ic_addr_ok = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_3000;
    step();                                   // CANCEL
    ic_addr_ok = 1'b0; redirect_valid = 1'b0; mmu_psyaddr = 32'h0000_3000;
    settle();
    chk("t7_cancel_mmu_en", {31'd0, mmu_en}, 32'd0);
    chk("t7_cancel_no_req", {31'd0, ic_req}, 32'd0);
    ic_data_ok = 1'b1; ic_rdata = 32'h5555_AAAA;
    step();                                   // REQ
    ic_data_ok = 1'b0;
    settle();
    chk("t7_vaddr", mmu_vaddr, 32'h8000_3000);
    chk("t7_no_bundle", {31'd0, out_valid}, 32'd0);

    // ---------------- 8: reset mid-request ----------------
    ic_addr_ok = 1'b1;
    step();                                   // WAIT
    ic_addr_ok = 1'b0; mmu_psyaddr_ena = 1'b0;
    resetn = 1'b0;
    settle();
    chk("t8_rst_vaddr", mmu_vaddr, 32'hBFC0_0000);
    chk("t8_rst_mmu_en", {31'd0, mmu_en}, 32'd1);
    chk("t8_rst_valid", {31'd0, out_valid}, 32'd0);
    step();
    resetn = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
